rob_recover_nway: RTL
=====================

# rob_recover_nway

Parametrised reorder buffer that succeeds the fixed-width ROB wrapper. It accepts up to `WAYS` renamed instructions per cycle, marks them done from `CPORTS` completion ports addressed by ROB index, and retires up to `WAYS` in order. It also supports early branch-misprediction recovery: the tail is rolled back to just after the mispredicted branch, so the pipeline does not have to wait for the branch to reach retirement and flush everything. It sits between rename/dispatch and the architectural map table / free list.

## Interface
Parameters:
- `WAYS`, 2: dispatch and retire width.
- `DEPTH`, 16: number of entries; must be a power of two and at least `WAYS`.
- `CPORTS`, 2: number of completion ports.
- `TAG_W`, 6: physical register tag width.
- `XLEN`, 32: PC width.
- `IDX_W`, $clog2(DEPTH): ROB index width.

Ports:
- `clock` in 1: the only clock. Rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `dis_valid` in WAYS: dispatch requests. Must be contiguous from bit 0.
- `dis_tag`, `dis_tag_old` in WAYS×TAG_W: new and previous physical tags.
- `dis_pc` in WAYS×XLEN: instruction PCs.
- `dis_halt` in WAYS: instruction is a halt.
- `dis_ready` out WAYS: per-way acceptance this cycle.
- `dis_idx` out WAYS×IDX_W: index that each way is allocated to.
- `cmp_valid` in CPORTS, `cmp_idx` in CPORTS×IDX_W: completion by ROB index.
- `mp_valid` in 1, `mp_idx` in IDX_W: mispredicted branch index.
- `ret_valid` out WAYS: retire strobes. Contiguous from bit 0.
- `ret_tag`, `ret_tag_old` out WAYS×TAG_W: tags of retiring entries.
- `ret_pc` out WAYS×XLEN: PCs of retiring entries.
- `ret_halt` out WAYS: retiring entry is a halt.
- `free_count` out IDX_W+1: number of empty entries.
- `halted` out 1: sticky; set once a halt has retired.

## Operation
State:
- `head` (IDX_W), `tail` (IDX_W), `count` (IDX_W+1).
- Per entry: `tag`, `tag_old`, `pc`, `halt`, `done`.
- `halted`.

Reset values:
- `head = tail = count = 0`; all `done = 0`; `halted = 0`.
- Resulting outputs: `ret_valid = 0`, `free_count = DEPTH`, `dis_ready = all 1`, `dis_idx[i] = i`, `halted = 0`.

Dispatch:
- `dis_ready[i] = !halted && !mp_valid && (i < free_count)`.
- `dis_idx[i] = (tail + i) mod DEPTH`.
- Accepted ways (`dis_valid & dis_ready`) are written at the edge with `done = 0`. `tail` advances by the accepted count and wraps mod DEPTH.

Completion:
- For each port with `cmp_valid`, set `done[cmp_idx]` at the edge.
- A completion to an empty slot, or to a slot squashed in the same cycle, is ignored.
- Duplicate indices across ports are harmless.

Retire:
- Candidate k (k = 0..WAYS-1) is entry `head + k`.
- `ret_valid[k]` is asserted when all of the following hold:
  - k < count;
  - `done` is set for candidates 0..k;
  - no candidate j < k has `halt` set;
  - if `mp_valid`, `(head + k - head) mod DEPTH <= (mp_idx - head) mod DEPTH`.
- The net effect is that retirement stops at the first not-done entry, retires a halt as the last entry of the cycle, and never retires past the mispredicted branch.
- On the edge, `head` advances by the retired count and the retired entries' `done` bits are cleared. If any retired entry has `halt`, `halted` is set.

Misprediction:
- At the edge, `tail = mp_idx + 1` (mod DEPTH).
- `count = ((mp_idx - head) mod DEPTH) + 1 - retired`.
- The `done` bits of squashed entries are cleared.
- `mp_idx` must name an occupied entry; behaviour is undefined otherwise.

Count update (no misprediction): `count_next = count + accepted - retired`.

## Timing
- Dispatch at edge N makes the entry occupied in cycle N+1.
- Completion presented in cycle C sets `done` at the edge; `ret_valid` can rise in cycle C+1. Minimum dispatch→retire is 2 cycles.
- No same-cycle bypass. Slots freed by retire in cycle R become available to dispatch from cycle R+1.
- `mp_valid` forces `dis_ready = 0` in the same cycle. The front end re-dispatches from cycle +1.
- `ret_*`, `dis_ready` and `free_count` are combinational from state. `ret_valid` additionally depends combinationally on `mp_valid` and `mp_idx`.
- Full (count = DEPTH): `dis_ready = 0`. If retire and dispatch attempt in the same cycle while full, dispatch is refused.
- Asserting `reset` mid-operation clears everything immediately. In-flight dispatches and completions are dropped.

## Test plan
- Reset, then dispatch 2/cycle for 8 cycles with DEPTH=16 -> `free_count` 16→0. Ninth cycle: `dis_ready = 00`.
- Full ROB at head=0, complete idx 0 and 1, with `dis_valid = 11` in the following cycle -> `ret_valid = 11` with the correct tags, `dis_ready = 00` that cycle, `dis_ready = 11` the next cycle.
- Complete idx 1 only -> `ret_valid = 00`. Later complete idx 0 -> `ret_valid = 11` one cycle later.
- 10 entries at head=14, mp_idx=1 with entries 14–15 done -> `ret_valid = 11`, then `tail = 2`, `count = 2` (entries 0,1), `free_count = 14`.
- Halt at idx 3 with idx 4 done and head=3 -> `ret_valid = 01`, `halted = 1`, all later `dis_ready = 0`.
- Mispredict at idx 5 with head=5, entries 5 and 6 done -> `ret_valid = 01`, entry 6 squashed, `count = 0`.

Source files
------------

// File: rtl/rob_recover_nway.sv
// Reorder buffer with WAYS-wide dispatch/retire, indexed completion ports and
// early branch-misprediction recovery that rolls the tail back behind the branch.
module rob_recover_nway #(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CPORTS = 2,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WAYS-1:0]         dis_valid,
    input  logic [WAYS*TAG_W-1:0]   dis_tag,
    input  logic [WAYS*TAG_W-1:0]   dis_tag_old,
    input  logic [WAYS*XLEN-1:0]    dis_pc,
    input  logic [WAYS-1:0]         dis_halt,
    output logic [WAYS-1:0]         dis_ready,
    output logic [WAYS*IDX_W-1:0]   dis_idx,
    input  logic [CPORTS-1:0]       cmp_valid,
    input  logic [CPORTS*IDX_W-1:0] cmp_idx,
    input  logic                    mp_valid,
    input  logic [IDX_W-1:0]        mp_idx,
    output logic [WAYS-1:0]         ret_valid,
    output logic [WAYS*TAG_W-1:0]   ret_tag,
    output logic [WAYS*TAG_W-1:0]   ret_tag_old,
    output logic [WAYS*XLEN-1:0]    ret_pc,
    output logic [WAYS-1:0]         ret_halt,
    output logic [IDX_W:0]          free_count,
    output logic                    halted
);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [TAG_W-1:0] tag_q     [DEPTH];
    logic [TAG_W-1:0] tag_d     [DEPTH];
    logic [TAG_W-1:0] tag_old_q [DEPTH];
    logic [TAG_W-1:0] tag_old_d [DEPTH];
    logic [XLEN-1:0]  pc_q      [DEPTH];
    logic [XLEN-1:0]  pc_d      [DEPTH];
    logic [DEPTH-1:0] halt_q, halt_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halted_q, halted_d;

    logic [IDX_W-1:0] mp_off;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] off;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] acc_cnt;
    logic [WAYS-1:0]  acc;
    logic             chain;

    assign halted = halted_q;

    always_comb begin
        tag_d       = tag_q;
        tag_old_d   = tag_old_q;
        pc_d        = pc_q;
        halt_d      = halt_q;
        done_d      = done_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        halted_d    = halted_q;
        idx         = '0;
        off         = '0;
        chain       = 1'b1;
        ret_cnt     = '0;
        acc_cnt     = '0;
        acc         = '0;
        ret_valid   = '0;
        ret_tag     = '0;
        ret_tag_old = '0;
        ret_pc      = '0;
        ret_halt    = '0;
        dis_ready   = '0;
        dis_idx     = '0;
        mp_off      = mp_idx - head_q;
        free_count  = CNT_W'(DEPTH) - count_q;

        // Completions land only on occupied slots that survive a same-cycle squash.
        for (int unsigned c = 0; c < CPORTS; c++) begin
            idx = cmp_idx[c*IDX_W +: IDX_W];
            off = idx - head_q;
            if (cmp_valid[c] && (CNT_W'(off) < count_q) && (!mp_valid || off <= mp_off))
                done_d[idx] = 1'b1;
        end

        // In-order retire: stop at first not-done, after a halt, or past the branch.
        for (int unsigned k = 0; k < WAYS; k++) begin
            idx   = head_q + IDX_W'(k);
            chain = chain && (CNT_W'(k) < count_q) && done_q[idx] &&
                    (!mp_valid || IDX_W'(k) <= mp_off);
            ret_valid[k] = chain;
            chain = chain && !halt_q[idx];
            ret_tag[k*TAG_W +: TAG_W]     = tag_q[idx];
            ret_tag_old[k*TAG_W +: TAG_W] = tag_old_q[idx];
            ret_pc[k*XLEN +: XLEN]        = pc_q[idx];
            ret_halt[k]                   = halt_q[idx];
            ret_cnt = ret_cnt + CNT_W'(ret_valid[k]);
            if (ret_valid[k]) begin
                done_d[idx] = 1'b0;
                if (halt_q[idx])
                    halted_d = 1'b1;
            end
        end

        if (mp_valid) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                idx = IDX_W'(e);
                off = idx - head_q;
                if (off > mp_off)
                    done_d[idx] = 1'b0;
            end
        end

        for (int unsigned i = 0; i < WAYS; i++) begin
            idx = tail_q + IDX_W'(i);
            dis_idx[i*IDX_W +: IDX_W] = idx;
            dis_ready[i] = !halted_q && !mp_valid && (CNT_W'(i) < free_count);
            acc[i]       = dis_valid[i] && dis_ready[i];
            acc_cnt      = acc_cnt + CNT_W'(acc[i]);
            if (acc[i]) begin
                tag_d[idx]     = dis_tag[i*TAG_W +: TAG_W];
                tag_old_d[idx] = dis_tag_old[i*TAG_W +: TAG_W];
                pc_d[idx]      = dis_pc[i*XLEN +: XLEN];
                halt_d[idx]    = dis_halt[i];
                done_d[idx]    = 1'b0;
            end
        end

        head_d = head_q + IDX_W'(ret_cnt);
        if (mp_valid) begin
            tail_d  = mp_idx + IDX_W'(1);
            count_d = CNT_W'(mp_off) + CNT_W'(1) - ret_cnt;
        end else begin
            tail_d  = tail_q + IDX_W'(acc_cnt);
            count_d = count_q + acc_cnt - ret_cnt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                tag_q[e]     <= '0;
                tag_old_q[e] <= '0;
                pc_q[e]      <= '0;
            end
            halt_q   <= '0;
            done_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            tag_old_q <= tag_old_d;
            pc_q      <= pc_d;
            halt_q    <= halt_d;
            done_q    <= done_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            halted_q  <= halted_d;
        end
    end
endmodule
